// File: rtl/seq_mult_core.sv
// seq_mult_core: sequential signed add-shift multiplier, {X,A,B} = B * S.
// Ports: Clk, Reset (async, active-low); ClearA_LoadB clears A/X and loads B
// from S while idle; Run (level) starts a multiply; S is the operand;
// Aval/Bval/X hold the product; Busy/Done are decoded from the state register.
// Define SEQ_MULT_FAST_EN to merge add and shift into one STEP cycle per bit.
module seq_mult_core #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             ClearA_LoadB,
  input  logic             Run,
  input  logic [WIDTH-1:0] S,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             X,
  output logic             Busy,
  output logic             Done
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`ifdef SEQ_MULT_FAST_EN
  typedef enum logic [1:0] {S_IDLE, S_START, S_STEP, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_ADD, S_SHIFT, S_DONE} state_t;
`endif
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, m_q, m_d;
  logic [CW-1:0] count_q, count_d;
  logic x_q, x_d;
  logic [WIDTH:0] sum, ax;
  // The multiplier's top bit has negative weight, so the last partial product is subtracted.
  always_comb begin
    sum = (count_q == LAST) ? {a_q[WIDTH-1], a_q} - {m_q[WIDTH-1], m_q}
                            : {a_q[WIDTH-1], a_q} + {m_q[WIDTH-1], m_q};
    ax = b_q[0] ? sum : {x_q, a_q};
  end
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    m_d = m_q;
    x_d = x_q;
    count_d = count_q;
    unique case (state_q)
      S_IDLE: begin
        if (ClearA_LoadB) begin
          a_d = '0;
          x_d = 1'b0;
          b_d = S;
        end else if (Run) state_d = S_START;
      end
      S_START: begin
        a_d = '0;
        x_d = 1'b0;
        m_d = S;
        count_d = '0;
`ifdef SEQ_MULT_FAST_EN
        state_d = S_STEP;
`else
        state_d = S_ADD;
`endif
      end
`ifdef SEQ_MULT_FAST_EN
      S_STEP: begin
        {x_d, a_d, b_d} = {ax[WIDTH], ax, b_q[WIDTH-1:1]};
        count_d = (count_q == LAST) ? count_q : count_q + CW'(1);
        state_d = (count_q == LAST) ? S_DONE : S_STEP;
      end
`else
      S_ADD: begin
        {x_d, a_d} = ax;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        {x_d, a_d, b_d} = {x_q, x_q, a_q, b_q[WIDTH-1:1]};
        count_d = (count_q == LAST) ? count_q : count_q + CW'(1);
        state_d = (count_q == LAST) ? S_DONE : S_ADD;
      end
`endif
      S_DONE: state_d = Run ? S_DONE : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      a_q <= '0;
      b_q <= '0;
      m_q <= '0;
      x_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      m_q <= m_d;
      x_q <= x_d;
      count_q <= count_d;
    end
  end
  assign Aval = a_q;
  assign Bval = b_q;
  assign X = x_q;
  assign Done = state_q == S_DONE;
`ifdef SEQ_MULT_FAST_EN
  assign Busy = state_q == S_START || state_q == S_STEP;
`else
  assign Busy = state_q == S_START || state_q == S_ADD || state_q == S_SHIFT;
`endif
endmodule
